// File: rtl/present_nibble_serial_ctrl_pkg.sv
// Shared types, sizes and S-box helpers for the PRESENT nibble-serial controller.
// Optional fault injection is controlled by PRESENT_CTRL_FAULT_INJ_EN (see top).
package present_ctrl_pkg;
   localparam int NIBBLES = 16;
   localparam int STATE_W = 4 * NIBBLES;
   localparam int CNT_W   = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} ctrl_state_e;

   // Entry i lives in bits [4i+3:4i]: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
   localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

   function automatic logic [3:0] nibble_sel(input logic [STATE_W-1:0] vec,
                                             input logic [CNT_W-1:0]   idx);
      return vec[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TABLE[{x, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/present_nibble_serial_ctrl_if.sv
// Input/output valid-ready bus of the PRESENT nibble-serial controller.
// Unaffected by PRESENT_CTRL_FAULT_INJ_EN.
interface present_nibble_serial_ctrl_if;
   import present_ctrl_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_state;
   logic [STATE_W-1:0] in_key;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_data;

   modport master (output in_valid, in_state, in_key, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_state, in_key, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/present_sbox_keyadd_dup.sv
// Duplicated S-box + key-add on one nibble; output forced to 0 when branches disagree.
// With PRESENT_CTRL_FAULT_INJ_EN the redundant branch sees state ^ fault_inj.
module present_sbox_keyadd_dup
   import present_ctrl_pkg::*;
(
   input  logic [3:0] state_nib,
   input  logic [3:0] key_nib,
`ifdef PRESENT_CTRL_FAULT_INJ_EN
   input  logic [3:0] fault_inj,
`endif
   output logic [3:0] out_nib,
   output logic       error
);
   logic [3:0] red_in;
   logic [3:0] pri_out;
   logic [3:0] red_out;

`ifdef PRESENT_CTRL_FAULT_INJ_EN
   assign red_in = state_nib ^ fault_inj;
`else
   assign red_in = state_nib;
`endif

   assign pri_out = sbox(state_nib) ^ key_nib;
   assign red_out = sbox(red_in) ^ key_nib;
   assign error   = (pri_out != red_out);
   assign out_nib = error ? 4'h0 : pri_out;
endmodule

// File: rtl/present_nibble_serial_ctrl.sv
// Nibble-serial PRESENT S-box/key-add layer with duplicated datapath and sticky fault.
// Define PRESENT_CTRL_FAULT_INJ_EN to add the fault_inj test port.
//
// state | meaning
// IDLE  | in_ready high, waiting for state/key
// RUN   | one nibble per cycle through the duplicated datapath
// DONE  | result presented, held until out_ready
// FAULT | mismatch seen, result blanked, waiting for clear_fault
module present_nibble_serial_ctrl
   import present_ctrl_pkg::*;
#(
   parameter int FCNT_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   present_nibble_serial_ctrl_if.slave bus,
   output logic                       fault,
   output logic [3:0]                 fault_nibble,
   output logic [FCNT_W-1:0]          fault_count,
`ifdef PRESENT_CTRL_FAULT_INJ_EN
   input  logic [3:0]                 fault_inj,
`endif
   input  logic                       clear_fault
);
   ctrl_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STATE_W-1:0] st_q, st_d;
   logic [STATE_W-1:0] key_q, key_d;
   logic [STATE_W-1:0] result_q, result_d;
   logic               fault_q, fault_d;
   logic [3:0]         fnib_q, fnib_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [3:0]         dp_out;
   logic               dp_error;

   present_sbox_keyadd_dup u_dp (
      .state_nib (nibble_sel(st_q, cnt_q)),
      .key_nib   (nibble_sel(key_q, cnt_q)),
`ifdef PRESENT_CTRL_FAULT_INJ_EN
      .fault_inj ((state_q == RUN) ? fault_inj : 4'h0),
`endif
      .out_nib   (dp_out),
      .error     (dp_error)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         st_q     <= '0;
         key_q    <= '0;
         result_q <= '0;
         fault_q  <= 1'b0;
         fnib_q   <= 4'h0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         st_q     <= st_d;
         key_q    <= key_d;
         result_q <= result_d;
         fault_q  <= fault_d;
         fnib_q   <= fnib_d;
         fcnt_q   <= fcnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      st_d          = st_q;
      key_d         = key_q;
      result_d      = result_q;
      fault_d       = fault_q;
      fnib_d        = fnib_q;
      fcnt_d        = fcnt_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               st_d     = bus.in_state;
               key_d    = bus.in_key;
               result_d = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (dp_error) begin
               state_d  = FAULT;
               result_d = '0;
               fnib_d   = 4'(cnt_q);
               fault_d  = 1'b1;
               if (fcnt_q != '1) fcnt_d = fcnt_q + FCNT_W'(1);
            end else begin
               result_d[{cnt_q, 2'b00} +: 4] = dp_out;
               if (cnt_q == CNT_W'(NIBBLES - 1)) state_d = DONE;
               else cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out_data  = result_q;
            if (bus.out_ready) state_d = IDLE;
         end
         FAULT: begin
            if (clear_fault) begin
               state_d = IDLE;
               fault_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fault        = fault_q;
   assign fault_nibble = fnib_q;
   assign fault_count  = fcnt_q;
endmodule

// File: tb/tb_present_nibble_serial_ctrl.sv
// Self-checking bench for present_nibble_serial_ctrl; fault tests need PRESENT_CTRL_FAULT_INJ_EN.
module tb_present_nibble_serial_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fault;
   logic [3:0] fault_nibble;
   logic [7:0] fault_count;
   logic       clear_fault;
`ifdef PRESENT_CTRL_FAULT_INJ_EN
   logic [3:0] fault_inj;
   int         exp_fcnt;
   int         nwait;
`endif
   int compared = 0;
   int mismatched = 0;
   int cyc;
   logic [63:0] s, k, exp_out;

   always #5 clk = ~clk;

   present_nibble_serial_ctrl_if bus ();

   present_nibble_serial_ctrl #(.FCNT_W(8)) dut (
      .clock        (clk),
      .reset        (rst_n),
      .bus          (bus.slave),
      .fault        (fault),
      .fault_nibble (fault_nibble),
      .fault_count  (fault_count),
`ifdef PRESENT_CTRL_FAULT_INJ_EN
      .fault_inj    (fault_inj),
`endif
      .clear_fault  (clear_fault)
   );

   // Reference: whole-block S-box layer followed by one wide XOR with the key.
   function automatic logic [63:0] ref_layer(input logic [63:0] st, input logic [63:0] ky);
      int unsigned sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
      logic [63:0] r = 64'h0;
      for (int i = 0; i < 16; i++) begin
         int idx = int'((st >> (4 * i)) & 64'hF);
         r = r | (64'(sb[idx]) << (4 * i));
      end
      return r ^ ky;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] st, input logic [63:0] ky);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_state = st;
      bus.in_key   = ky;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 64'(n < 50), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_state = {$urandom, $urandom};
      bus.in_key   = {$urandom, $urandom};
      check("busy_after_accept", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic wait_out(output int c);
      c = 0;
      while (!bus.out_valid && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("idle_after_take", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
      check("data_blank_idle", bus.out_data, 64'h0);
   endtask

   task automatic run_vec(input string tag, input logic [63:0] st, input logic [63:0] ky,
                          input logic [63:0] exp);
      int c;
      send(st, ky);
      wait_out(c);
      check({tag, "_latency"}, 64'(c), 64'd16);
      check({tag, "_data"}, bus.out_data, exp);
      check({tag, "_fault"}, 64'(fault), 64'd0);
      take_result();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_state  = 64'h0;
      bus.in_key    = 64'h0;
      bus.out_ready = 1'b0;
      clear_fault   = 1'b0;
`ifdef PRESENT_CTRL_FAULT_INJ_EN
      fault_inj     = 4'h0;
`endif
      #3;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", bus.out_data, 64'h0);
      check("rst_fault", {51'd0, fault, fault_nibble, fault_count}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec("zero", 64'h0, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC);
      run_vec("ramp_k0", 64'h0123_4567_89AB_CDEF, 64'h0, 64'hC56B_90AD_3EF8_4712);
      run_vec("ramp_kf", 64'h0123_4567_89AB_CDEF, '1, 64'h3A94_6F52_C107_B8ED);

      // Backpressure in DONE, then a back-to-back request.
      s = {$urandom, $urandom};
      k = {$urandom, $urandom};
      exp_out = ref_layer(s, k);
      send(s, k);
      wait_out(cyc);
      check("hold_latency", 64'(cyc), 64'd16);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_data", bus.out_data, exp_out);
         check("hold_flags", {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
      end
      s = {$urandom, $urandom};
      k = {$urandom, $urandom};
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_state  = s;
      bus.in_key    = k;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("b2b_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_state = ~s;
      check("b2b_accepted", 64'(bus.in_ready), 64'd0);
      wait_out(cyc);
      check("b2b_latency", 64'(cyc), 64'd16);
      check("b2b_data", bus.out_data, ref_layer(s, k));
      take_result();

      for (int n = 0; n < 6; n++) begin
         s = {$urandom, $urandom};
         k = {$urandom, $urandom};
         run_vec("rand", s, k, ref_layer(s, k));
      end

      // Reset in the middle of RUN at cnt=9.
      send(64'h0123_4567_89AB_CDEF, '1);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_out", {63'd0, bus.out_valid}, 64'd0);
      check("midrst_data", bus.out_data, 64'h0);
      check("midrst_fault", {51'd0, fault, fault_nibble, fault_count}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec("after_rst", 64'h0123_4567_89AB_CDEF, '1, 64'h3A94_6F52_C107_B8ED);

`ifdef PRESENT_CTRL_FAULT_INJ_EN
      send({$urandom, $urandom}, {$urandom, $urandom});
      repeat (7) @(posedge clk);
      #1;
      fault_inj = 4'h1;
      @(posedge clk);
      #1;
      fault_inj = 4'h0;
      check("inj_fault", 64'(fault), 64'd1);
      check("inj_nibble", 64'(fault_nibble), 64'd7);
      check("inj_count", 64'(fault_count), 64'd1);
      check("inj_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'b00);
      check("inj_data", bus.out_data, 64'h0);
      @(negedge clk);
      clear_fault = 1'b1;
      @(posedge clk);
      #1;
      clear_fault = 1'b0;
      check("clr_fault", 64'(fault), 64'd0);
      check("clr_count", 64'(fault_count), 64'd1);
      check("clr_nibble", 64'(fault_nibble), 64'd7);
      check("clr_idle", 64'(bus.in_ready), 64'd1);
      exp_fcnt = 1;

      for (int n = 0; n < 300; n++) begin
         send({$urandom, $urandom}, {$urandom, $urandom});
         fault_inj = 4'(1 + $urandom_range(0, 14));
         nwait = 0;
         while (!fault && nwait < 50) begin
            @(posedge clk);
            #1;
            nwait++;
         end
         fault_inj = 4'h0;
         exp_fcnt = (exp_fcnt < 255) ? exp_fcnt + 1 : 255;
         check("sat_seen", 64'(fault), 64'd1);
         check("sat_count", 64'(fault_count), 64'(exp_fcnt));
         check("sat_nibble", 64'(fault_nibble), 64'd0);
         @(negedge clk);
         clear_fault = 1'b1;
         @(posedge clk);
         #1;
         clear_fault = 1'b0;
      end
      check("sat_final", 64'(fault_count), 64'd255);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
